// File: rtl/buffer_memory.sv
// Banked buffer: D parallel banks of 2^A words, written either all at once through the wide
// array port or one bank at a time through the narrow I/O port; both read ports are registered.
module buffer_memory #(
  parameter int depth = 2,
  parameter int A     = 7,
  parameter int W     = 16
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  input  logic [A-1:0]              address,
  input  logic                      ioSelect,
  input  logic                      write,
  input  logic [depth-1:0]          ioBankSelect,
  input  logic [W-1:0]              ioInput,
  input  logic [W*(1<<depth)-1:0]   ip,
  output logic [W*(1<<depth)-1:0]   op,
  output logic [W-1:0]              ioOut
);

  localparam int D = 1 << depth;

  logic [W-1:0] mem_r [D][1<<A];
  logic [D-1:0] bankWe_s;
  logic [W-1:0] bankWd_s [D];

  // Per-bank write enable and data, steered by the port select.
  always_comb begin
    for (int b = 0; b < D; b++) begin
      bankWe_s[b] = 1'b0;
      bankWd_s[b] = ip[W*b +: W];
      if (!write) begin
        bankWe_s[b] = 1'b0;
      end else if (ioSelect) begin
        bankWe_s[b] = (ioBankSelect == depth'(b));
        bankWd_s[b] = ioInput;
      end else begin
        bankWe_s[b] = 1'b1;
      end
    end
  end

  // Storage and registered read ports; reads sample the old word, so a same-cycle write
  // only becomes visible on the next access. Reset clears the outputs but never the banks.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      op    <= {(W*D){1'b0}};
      ioOut <= {W{1'b0}};
    end else begin
      for (int b = 0; b < D; b++) begin
        if (bankWe_s[b]) begin
          mem_r[b][address] <= bankWd_s[b];
        end
        op[W*b +: W] <= mem_r[b][address];
      end
      ioOut <= mem_r[ioBankSelect][address];
    end
  end

endmodule

// File: tb/tb_buffer_memory.sv
// Scoreboard bench for buffer_memory: the driver pushes expected read data from an array model,
// a monitor compares the registered outputs after every rising edge.
module tb_buffer_memory;

  logic        CLK;
  logic        RSTn;
  logic [6:0]  address;
  logic        ioSelect;
  logic        write;
  logic [1:0]  ioBankSelect;
  logic [15:0] ioInput;
  logic [63:0] ip;
  logic [63:0] op;
  logic [15:0] ioOut;

  logic [15:0] model [4][128];
  logic [63:0] expOpQ [$];
  logic [15:0] expIoQ [$];
  string       nameQ  [$];
  bit          chkQ   [$];

  int checks   = 0;
  int failures = 0;

  buffer_memory #(.depth(2), .A(7), .W(16)) dut (
    .CLK(CLK), .RSTn(RSTn), .address(address), .ioSelect(ioSelect), .write(write),
    .ioBankSelect(ioBankSelect), .ioInput(ioInput), .ip(ip), .op(op), .ioOut(ioOut)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: one expected entry per rising edge, compared just after the edge.
  always @(posedge CLK) begin
    #1;
    if (expOpQ.size() > 0) begin
      logic [63:0] eo;
      logic [15:0] ei;
      string       nm;
      bit          c;
      eo = expOpQ.pop_front();
      ei = expIoQ.pop_front();
      nm = nameQ.pop_front();
      c  = chkQ.pop_front();
      if (c) begin
        check({nm, ".op"}, op, eo);
        check({nm, ".ioOut"}, {48'h0, ioOut}, {48'h0, ei});
      end
    end
  end

  // One access cycle, driven just after a falling edge; returns at the next falling edge.
  task automatic step(input logic sel, input logic wr, input logic [1:0] bank,
                      input logic [6:0] addr, input logic [15:0] ioIn, input logic [63:0] ipv,
                      input string nm, input bit chk, input bit hasOp, input logic [63:0] cOp,
                      input bit hasIo, input logic [15:0] cIo);
    logic [63:0] mOp;
    logic [15:0] mIo;
    ioSelect     = sel;
    write        = wr;
    ioBankSelect = bank;
    address      = addr;
    ioInput      = ioIn;
    ip           = ipv;
    for (int b = 0; b < 4; b++) mOp[16*b +: 16] = model[b][addr];
    mIo = model[bank][addr];
    if (!RSTn) begin
      mOp = 64'h0;
      mIo = 16'h0;
    end else begin
      if (hasOp) mOp = cOp;
      if (hasIo) mIo = cIo;
    end
    expOpQ.push_back(mOp);
    expIoQ.push_back(mIo);
    nameQ.push_back(nm);
    chkQ.push_back(chk);
    if (RSTn && wr) begin
      if (sel) model[bank][addr] = ioIn;
      else for (int b = 0; b < 4; b++) model[b][addr] = ipv[16*b +: 16];
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic ioWr(input logic [1:0] bank, input logic [6:0] addr, input logic [15:0] d, input string nm);
    step(1'b1, 1'b1, bank, addr, d, {$urandom, $urandom}, nm, 1'b1, 1'b0, 64'h0, 1'b0, 16'h0);
  endtask

  task automatic rd(input logic [1:0] bank, input logic [6:0] addr, input string nm,
                    input bit hasOp, input logic [63:0] cOp, input bit hasIo, input logic [15:0] cIo);
    step(1'($urandom_range(0, 1)), 1'b0, bank, addr, 16'($urandom), {$urandom, $urandom},
         nm, 1'b1, hasOp, cOp, hasIo, cIo);
  endtask

  task automatic randInputs();
    ioSelect     = 1'($urandom_range(0, 1));
    write        = 1'b1;
    ioBankSelect = 2'($urandom_range(0, 3));
    address      = 7'($urandom_range(0, 127));
    ioInput      = 16'($urandom);
    ip           = {$urandom, $urandom};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    RSTn = 1'b1;
    ioSelect = 1'b0; write = 1'b0; ioBankSelect = 2'd0; address = 7'd0;
    ioInput = 16'h0; ip = 64'h0;

    // Asynchronous reset between clock edges
    #3;
    randInputs();
    RSTn = 1'b0;
    #1;
    check("rst_async.op", op, 64'h0);
    check("rst_async.ioOut", {48'h0, ioOut}, 64'h0);
    @(negedge CLK);
    for (int i = 0; i < 2; i++)
      step(1'($urandom_range(0, 1)), 1'b1, 2'($urandom), 7'($urandom), 16'($urandom),
           {$urandom, $urandom}, "rst_hold", 1'b1, 1'b0, 64'h0, 1'b0, 16'h0);
    RSTn = 1'b1;

    // Fill every address so later reads are fully defined
    for (int a = 0; a < 128; a++)
      step(1'b0, 1'b1, 2'($urandom), 7'(a), 16'($urandom), {$urandom, $urandom},
           "fill", 1'b0, 1'b0, 64'h0, 1'b0, 16'h0);

    // Reset with a write pending: dropped, then stored contents readable
    randInputs();
    RSTn = 1'b0;
    #1;
    check("rst2_async.op", op, 64'h0);
    check("rst2_async.ioOut", {48'h0, ioOut}, 64'h0);
    step(ioSelect, 1'b1, ioBankSelect, 7'd0, ioInput, ip, "rst2_hold", 1'b1, 1'b0, 64'h0, 1'b0, 16'h0);
    RSTn = 1'b1;
    rd(2'd1, 7'd0, "post_rst_rd0", 1'b0, 64'h0, 1'b0, 16'h0);

    // Single-word writes to each bank, then readback
    ioWr(2'd0, 7'd5, 16'h1111, "iow0");
    ioWr(2'd1, 7'd5, 16'h2222, "iow1");
    ioWr(2'd2, 7'd5, 16'h3333, "iow2");
    ioWr(2'd3, 7'd5, 16'h4444, "iow3");
    rd(2'd2, 7'd5, "io_rd5", 1'b1, 64'h4444_3333_2222_1111, 1'b1, 16'h3333);

    // Wide array write at the top address
    step(1'b0, 1'b1, 2'($urandom), 7'd127, 16'($urandom), 64'hDEAD_BEEF_CAFE_F00D,
         "arr_wr127", 1'b1, 1'b0, 64'h0, 1'b0, 16'h0);
    rd(2'd1, 7'd127, "arr_rd_b1", 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 16'hCAFE);
    rd(2'd3, 7'd127, "arr_rd_b3", 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 16'hDEAD);

    // Bank isolation at address 0
    ioWr(2'd3, 7'd0, 16'hAAAA, "iso_wr");
    rd(2'd3, 7'd0, "iso_b3", 1'b0, 64'h0, 1'b1, 16'hAAAA);
    for (int b = 0; b < 3; b++) rd(2'(b), 7'd0, "iso_other", 1'b0, 64'h0, 1'b0, 16'h0);

    // Read during write returns the old word
    ioWr(2'd0, 7'd9, 16'h0001, "rdw_init");
    step(1'b1, 1'b1, 2'd0, 7'd9, 16'h0002, 64'h0, "rdw_old", 1'b1, 1'b0, 64'h0, 1'b1, 16'h0001);
    rd(2'd0, 7'd9, "rdw_new", 1'b0, 64'h0, 1'b1, 16'h0002);

    // Reset on the same edge as a write: write dropped
    RSTn = 1'b0;
    #1;
    check("rst3_async.op", op, 64'h0);
    check("rst3_async.ioOut", {48'h0, ioOut}, 64'h0);
    step(1'b1, 1'b1, 2'd0, 7'd9, 16'hFFFF, 64'h0, "rst3_hold", 1'b1, 1'b0, 64'h0, 1'b0, 16'h0);
    RSTn = 1'b1;
    rd(2'd0, 7'd9, "rst3_kept", 1'b0, 64'h0, 1'b1, 16'h0002);

    // Random traffic with occasional reset cycles
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        RSTn = 1'b0;
        step(1'($urandom_range(0, 1)), 1'b1, 2'($urandom), 7'($urandom), 16'($urandom),
             {$urandom, $urandom}, "rnd_rst", 1'b1, 1'b0, 64'h0, 1'b0, 16'h0);
        RSTn = 1'b1;
      end else begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom),
             7'($urandom), 16'($urandom), {$urandom, $urandom}, "rnd", 1'b1,
             1'b0, 64'h0, 1'b0, 16'h0);
      end
    end

    @(posedge CLK);
    #3;
    check("drain", 64'(expOpQ.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
